// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_seq_pkg
//  Description : Shared types and helpers for the MAC sequencing controller.
//                Provides the controller state encoding and a clog2 helper
//                that never returns less than 1 (so 1-entry ranges still
//                get a 1-bit index).
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_e;

    function automatic int clog2_min1(input int value);
        if (value <= 1) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/valid_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : valid_delay_line
//  Description : DEPTH-stage shift register of WIDTH-bit words with a
//                synchronous flush. The word presented on in_data appears
//                on out_data exactly DEPTH cycles later.
//  Ports       : clk      - clock
//                reset    - synchronous active-high reset, clears all stages
//                flush    - synchronous clear of all stages (drops in_data)
//                in_data  - word entering stage 0
//                out_data - word leaving the last stage
//  Revision    : 1.0 - initial release
// ============================================================================
module valid_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_stage[0] <= '0;
        end else begin
            r_stage[0] <= in_data;
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    r_stage[gi] <= '0;
                end else begin
                    r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    assign out_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mac_seq_ctrl
//  Description : Sequencing controller for the matrix-multiply datapath.
//                After start it issues ROWS*COLS*INNER MAC operations (k
//                fastest, then col, then row), tags every final-k issue for
//                write-back through a PIPE_LAT-deep delay line, drains the
//                pipeline and then reports done together with the number
//                of cycles spent in RUN+DRAIN.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start, abort        - run control
//                busy, done          - status (RUN|DRAIN, DONE)
//                mac_en, acc_clr     - MAC issue strobe, accumulator clear
//                row_idx/col_idx/k_idx - issue indices
//                wr_en/wr_row/wr_col - result write-back
//                cycle_count         - RUN+DRAIN cycles of current/last run
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int ROWS     = 2,
    parameter int COLS     = 2,
    parameter int INNER    = 3,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 16,
    localparam int RW      = clog2_min1(ROWS),
    localparam int CW      = clog2_min1(COLS),
    localparam int KW      = clog2_min1(INNER)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             mac_en,
    output logic             acc_clr,
    output logic [RW-1:0]    row_idx,
    output logic [CW-1:0]    col_idx,
    output logic [KW-1:0]    k_idx,
    output logic             wr_en,
    output logic [RW-1:0]    wr_row,
    output logic [CW-1:0]    wr_col,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW    = clog2_min1(PIPE_LAT);
    localparam int TAG_W = 1 + RW + CW;

    localparam logic [1:0] c_st_idle  = 2'(IDLE);
    localparam logic [1:0] c_st_run   = 2'(RUN);
    localparam logic [1:0] c_st_drain = 2'(DRAIN);
    localparam logic [1:0] c_st_done  = 2'(DONE);

    localparam logic [RW-1:0] c_row_last   = RW'(ROWS - 1);
    localparam logic [CW-1:0] c_col_last   = CW'(COLS - 1);
    localparam logic [KW-1:0] c_k_last     = KW'(INNER - 1);
    localparam logic [DW-1:0] c_drain_last = DW'(PIPE_LAT - 1);

    logic [1:0]       r_state;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [KW-1:0]    r_k;
    logic [DW-1:0]    r_drain;
    logic [CNT_W-1:0] r_count;

    logic             w_in_run;
    logic             w_in_drain;
    logic             w_last_k;
    logic             w_last_col;
    logic             w_final_issue;
    logic             w_flush;
    logic [TAG_W-1:0] w_tag_in;
    logic [TAG_W-1:0] w_tag_out;

    assign w_in_run      = (r_state == c_st_run);
    assign w_in_drain    = (r_state == c_st_drain);
    assign w_last_k      = (r_k == c_k_last);
    assign w_last_col    = (r_col == c_col_last);
    assign w_final_issue = w_last_k && w_last_col && (r_row == c_row_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_drain <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start && !abort) begin
                        r_state <= c_st_run;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_k     <= '0;
                        r_count <= '0;
                    end
                end
                c_st_run: begin
                    r_count <= r_count + 1'b1;
                    if (abort || w_final_issue) begin
                        // Both exits leave the indices parked at zero.
                        r_state <= abort ? c_st_idle : c_st_drain;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_k     <= '0;
                        r_drain <= '0;
                    end else if (!w_last_k) begin
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_k <= '0;
                        if (!w_last_col) begin
                            r_col <= r_col + 1'b1;
                        end else begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                c_st_drain: begin
                    r_count <= r_count + 1'b1;
                    if (abort) begin
                        r_state <= c_st_idle;
                        r_drain <= '0;
                    end else if (r_drain == c_drain_last) begin
                        r_state <= c_st_done;
                        r_drain <= '0;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                c_st_done: begin
                    // abort wins over start when both are raised in DONE.
                    if (abort) begin
                        r_state <= c_st_idle;
                    end else if (start) begin
                        r_state <= c_st_run;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_k     <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Abort during an active run drops every write-back still in flight,
    // including the tag being issued in the abort cycle.
    assign w_flush = abort && (w_in_run || w_in_drain);

    // Non-final issues enter as all-zero words, so wr_row/wr_col read 0
    // whenever wr_en is low without any output masking.
    assign w_tag_in = (mac_en && w_last_k) ? {1'b1, r_row, r_col} : '0;

    valid_delay_line #(
        .DEPTH (PIPE_LAT),
        .WIDTH (TAG_W)
    ) u_tag_delay (
        .clk      (clk),
        .reset    (reset),
        .flush    (w_flush),
        .in_data  (w_tag_in),
        .out_data (w_tag_out)
    );

    assign busy        = w_in_run || w_in_drain;
    assign done        = (r_state == c_st_done);
    assign mac_en      = w_in_run;
    assign acc_clr     = w_in_run && (r_k == '0);
    assign row_idx     = r_row;
    assign col_idx     = r_col;
    assign k_idx       = r_k;
    assign wr_en       = w_tag_out[TAG_W-1];
    assign wr_row      = w_tag_out[CW +: RW];
    assign wr_col      = w_tag_out[0 +: CW];
    assign cycle_count = r_count;

endmodule
`default_nettype wire
